imm_ext_pipe: RTL
=================

# imm_ext_pipe

Registered, parametrised immediate-extension stage for the pipelined core, placed between instruction decode and the execute-stage operand muxes. Given a 32-bit instruction word, the PC+4 value and an extension opcode, it produces an XLEN-bit operand: zero-, sign-, shamt-, LUI-, branch-offset or jump-target form. A 2-entry elastic buffer with a valid/ready handshake on both sides lets decode and execute stall independently without losing or duplicating an instruction, and a flush discards all buffered entries.

## Interface
- XLEN, default 32, operand width; legal values 32 or 64.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered entries; synchronous.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept; registered.
- instr  in  32  instruction word.
- pc_plus4  in  XLEN  PC of the instruction plus 4.
- ext_op  in  3  extension mode.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- imm_out  out  XLEN  extended operand of the head entry.
- br_target  out  XLEN  branch target of the head entry (see Configuration).
- op_err  out  1  head entry used a reserved ext_op.

## Operation
- imm16 = instr[15:0], sext(x) = sign extension to XLEN.
- ext_op 000: zero-extend imm16.
- ext_op 001: sext(imm16).
- ext_op 010: zero-extend instr[10:6] (shamt).
- ext_op 011: sext({imm16, 16'h0000}). For XLEN=32 this equals {imm16, 16'h0000}.
- ext_op 100: sext(imm16) << 2. Result is truncated to XLEN.
- ext_op 101: {pc_plus4[XLEN-1:28], instr[25:0], 2'b00}.
- ext_op 110/111: reserved; imm_out is the zero-extended imm16 and op_err=1, carried with the entry.
- Extension is computed combinationally on the input and stored with the entry. The pc_plus4 value is stored only when IMM_EXT_BRANCH_TGT_EN is defined.
- Buffer states:
  - EMPTY (0 entries) -> ONE on accept.
  - ONE -> TWO on accept without pop.
  - ONE -> EMPTY on pop without accept.
  - ONE -> ONE on simultaneous accept and pop.
  - TWO -> ONE on pop.
- Definitions: accept = in_valid && in_ready; pop = out_valid && out_ready.
- Entries leave in FIFO order. The head is always the oldest entry.
- in_ready = (state != TWO), registered from the next state.
- In TWO, in_valid is ignored; no overwrite.

## Timing
- Reset: state EMPTY, in_ready=1, out_valid=0, imm_out=0, br_target=0, op_err=0.
- Latency: an entry accepted in cycle N is presented with out_valid=1 in cycle N+1.
- Throughput: one entry per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, imm_out, br_target and op_err hold stable.
- Flush: the next state is EMPTY regardless of in_valid, out_ready or state. The input entry presented in the flush cycle is dropped, and in_ready=1 in the following cycle.
- Flush and reset have the same effect on state. Reset also clears the data outputs.
- rst asserted mid-transfer: the entry is lost, and outputs take reset values immediately (asynchronous).
- No combinational path from out_ready to in_ready or from in_valid to out_valid.

## Configuration
- IMM_EXT_BRANCH_TGT_EN defined:
  - Each entry also stores br_target = pc_plus4 + (sext(imm16) << 2), computed modulo 2^XLEN.
  - br_target is valid for every ext_op; downstream uses it only for branches.
- IMM_EXT_BRANCH_TGT_EN undefined:
  - No adder and no pc_plus4 storage.
  - br_target is constant 0.
  - All other behaviour is unchanged.

## Test plan
- Modes, XLEN=32, out_ready=1, imm16=16'h8004: ext_op 000 -> 32'h00008004; 001 -> 32'hFFFF8004; 011 -> 32'h80040000; 100 -> 32'hFFFE0010. Each appears one cycle after accept.
- Jump: instr=32'h0BFFFFFF, pc_plus4=32'h40000004, ext_op 101 -> imm_out=32'h4FFFFFFC. With IMM_EXT_BRANCH_TGT_EN and instr imm16=16'hFFFF, pc_plus4=32'h00000010 -> br_target=32'h0000000C.
- Backpressure: hold out_ready=0 and push A, B, C back-to-back. in_ready drops after B and C is not accepted. Release out_ready to get A then B, then retry C, with no loss or duplication.
- Flush in TWO with in_valid=1: next cycle out_valid=0 and in_ready=1; the dropped input never appears.
- Reserved/XLEN=64: ext_op 111 -> op_err=1 with imm_out=zero-extended imm16. With XLEN=64, ext_op 001 on imm16=16'hFFFF -> 64'hFFFFFFFFFFFFFFFF.
- Async reset asserted mid-stall with 2 entries: out_valid=0 and imm_out=0 before the next clock edge, and in_ready=1.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate-extension stage with a 2-entry elastic
// buffer between decode and execute. Optional build macro:
//   IMM_EXT_BRANCH_TGT_EN - store pc_plus4 + (sext(imm16) << 2) per entry and
//                           drive it on br_target; otherwise br_target is 0.
module imm_ext_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [2:0]      ext_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_out,
    output logic [XLEN-1:0] br_target,
    output logic            op_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_next;

    logic            accept, pop;
    logic            load_head, load_tail, head_from_tail;
    logic [XLEN-1:0] sext16;
    logic [XLEN-1:0] new_imm;
    logic            new_err;
    logic [XLEN-1:0] head_imm, tail_imm;
    logic            head_err, tail_err;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign sext16    = XLEN'($signed(instr[15:0]));

    // Extension of the incoming word; reserved modes fall back to zero-extend.
    always_comb begin
        new_imm = XLEN'(instr[15:0]);
        new_err = 1'b0;
        case (ext_op)
            3'b000:  new_imm = XLEN'(instr[15:0]);
            3'b001:  new_imm = sext16;
            3'b010:  new_imm = XLEN'(instr[10:6]);
            3'b011:  new_imm = XLEN'($signed({instr[15:0], 16'h0000}));
            3'b100:  new_imm = sext16 << 2;
            3'b101:  new_imm = {pc_plus4[XLEN-1:28], instr[25:0], 2'b00};
            default: begin
                new_imm = XLEN'(instr[15:0]);
                new_err = 1'b1;
            end
        endcase
    end

    // Buffer occupancy next state; flush wins over everything.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = ONE;
            ONE: begin
                if (accept && !pop)      state_next = TWO;
                else if (pop && !accept) state_next = EMPTY;
            end
            TWO:     if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
        if (flush) state_next = EMPTY;
    end

    // State register and registered in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != TWO);
        end
    end

    // Head reloads when it is empty-and-filled, replaced in ONE, or shifted in TWO.
    assign head_from_tail = (state == TWO);
    assign load_head = !flush && (((state == EMPTY) && accept) ||
                                  ((state == ONE) && accept && pop) ||
                                  ((state == TWO) && pop));
    assign load_tail = !flush && (state == ONE) && accept && !pop;

    // Entry storage for extended operand and reserved-op flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_imm <= '0;
            head_err <= 1'b0;
            tail_imm <= '0;
            tail_err <= 1'b0;
        end else begin
            if (load_head) begin
                head_imm <= head_from_tail ? tail_imm : new_imm;
                head_err <= head_from_tail ? tail_err : new_err;
            end
            if (load_tail) begin
                tail_imm <= new_imm;
                tail_err <= new_err;
            end
        end
    end

    assign imm_out = head_imm;
    assign op_err  = head_err;

`ifdef IMM_EXT_BRANCH_TGT_EN
    logic [XLEN-1:0] new_tgt, head_tgt, tail_tgt;
    logic            unused_instr;

    assign new_tgt      = pc_plus4 + (sext16 << 2);
    assign unused_instr = ^instr[31:26];

    // Branch target travels with its entry exactly like the operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_tgt <= '0;
            tail_tgt <= '0;
        end else begin
            if (load_head) head_tgt <= head_from_tail ? tail_tgt : new_tgt;
            if (load_tail) tail_tgt <= new_tgt;
        end
    end

    assign br_target = head_tgt;
`else
    logic unused_bits;

    assign unused_bits = ^{instr[31:26], pc_plus4[27:0]};
    assign br_target   = '0;
`endif

endmodule
